// File: rtl/led_blink_interface_if.sv
// Request/status bundle between control logic and the LED blink driver.
// Control logic drives start/count; the driver returns led/busy/done.
// The driver ignores any start it receives while busy is high.
interface led_blink_interface_if #(
    parameter int CountWidth = 4
);
    logic                  start;
    logic [CountWidth-1:0] count;
    logic                  led;
    logic                  busy;
    logic                  done;

    // Control-logic side: issues requests and observes status
    modport master (
        output start,
        output count,
        input  led,
        input  busy,
        input  done
    );

    // Driver side: accepts requests and reports status
    modport slave (
        input  start,
        input  count,
        output led,
        output busy,
        output done
    );
endinterface

// File: rtl/led_blink_interface.sv
// Single-LED blinker: drives N on/off periods of fixed length per start request.
// Latency: led/busy rise one cycle after start is sampled; done pulses one cycle after the last off period.
// No backpressure: start is ignored while busy; the request is not queued or stalled.
module led_blink_interface #(
    parameter int OnCycles   = 8,   // 1..2**TimerWidth
    parameter int OffCycles  = 8,   // 1..2**TimerWidth
    parameter int CountWidth = 4,
    parameter int TimerWidth = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    led_blink_interface_if.slave bus
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StOn   = 2'd1;
    localparam logic [1:0] StOff  = 2'd2;

    // Timers count down to zero inclusive, so load period-1
    localparam logic [TimerWidth-1:0] OnLoad   = TimerWidth'(OnCycles - 1);
    localparam logic [TimerWidth-1:0] OffLoad  = TimerWidth'(OffCycles - 1);
    localparam logic [TimerWidth-1:0] TimerOne = TimerWidth'(1);
    localparam logic [CountWidth-1:0] CountOne = CountWidth'(1);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [CountWidth-1:0] remaining;
    logic [CountWidth-1:0] remaining_nxt;
    logic [TimerWidth-1:0] timer;
    logic [TimerWidth-1:0] timer_nxt;
    logic                  led_q;
    logic                  led_nxt;
    logic                  busy_q;
    logic                  busy_nxt;
    logic                  done_q;
    logic                  done_nxt;

    // Next-state logic: outputs are computed here and registered below,
    // so nothing on the bus is a combinational function of start/count
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        timer_nxt     = timer;
        led_nxt       = led_q;
        busy_nxt      = busy_q;
        done_nxt      = 1'b0;

        case (state)
            StIdle: begin
                if (bus.start) begin
                    if (bus.count != '0) begin
                        state_nxt     = StOn;
                        remaining_nxt = bus.count;
                        timer_nxt     = OnLoad;
                        led_nxt       = 1'b1;
                        busy_nxt      = 1'b1;
                    end else begin
                        // Empty request completes immediately
                        done_nxt = 1'b1;
                    end
                end
            end

            StOn: begin
                if (timer == '0) begin
                    state_nxt = StOff;
                    timer_nxt = OffLoad;
                    led_nxt   = 1'b0;
                end else begin
                    timer_nxt = timer - TimerOne;
                end
            end

            StOff: begin
                if (timer == '0) begin
                    // remaining only decrements while >1, so it never wraps
                    if (remaining > CountOne) begin
                        state_nxt     = StOn;
                        remaining_nxt = remaining - CountOne;
                        timer_nxt     = OnLoad;
                        led_nxt       = 1'b1;
                    end else begin
                        state_nxt = StIdle;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    timer_nxt = timer - TimerOne;
                end
            end

            default: begin
                // Unreachable encoding: recover to a quiet idle
                state_nxt     = StIdle;
                remaining_nxt = '0;
                timer_nxt     = '0;
                led_nxt       = 1'b0;
                busy_nxt      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any sequence without a done
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            remaining <= '0;
            timer     <= '0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            timer     <= timer_nxt;
            led_q     <= led_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
        end
    end

    assign bus.led  = led_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    // done is a completion marker and must never coincide with busy
    a_done_not_busy: assert property (@(posedge clock) disable iff (!reset)
        !(done_q && busy_q));

    // The LED is only ever lit inside a sequence
    a_led_implies_busy: assert property (@(posedge clock) disable iff (!reset)
        led_q |-> busy_q);

endmodule

// File: tb/tb_led_blink_interface.sv
// Scoreboard bench for led_blink_interface: expected led/busy/done per cycle are
// queued when a request is driven, then popped and compared each cycle.
module tb_led_blink_interface;

    localparam int OnCycles   = 3;
    localparam int OffCycles  = 2;
    localparam int CountWidth = 4;
    localparam int TimerWidth = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected {led, busy, done} for each upcoming cycle; empty means idle
    logic [2:0] exp_q[$];

    led_blink_interface_if #(.CountWidth(CountWidth)) bus ();

    led_blink_interface #(
        .OnCycles  (OnCycles),
        .OffCycles (OffCycles),
        .CountWidth(CountWidth),
        .TimerWidth(TimerWidth)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Reference model: append the cycle-by-cycle outputs an accepted request produces
    task automatic push_seq(input int n);
        if (n == 0) begin
            exp_q.push_back(3'b001);
        end else begin
            for (int b = 0; b < n; b++) begin
                for (int k = 0; k < OnCycles; k++)  exp_q.push_back(3'b110);
                for (int k = 0; k < OffCycles; k++) exp_q.push_back(3'b010);
            end
            exp_q.push_back(3'b001);
        end
    endtask

    task automatic test_reset();
        logic [2:0] obs;
        bus.start = 1'b0;
        bus.count = '0;
        #1 reset = 1'b0;
        for (int cyc = 1; cyc <= 2; cyc++) begin
            @(negedge clock);
            obs = {bus.led, bus.busy, bus.done};
            n_cmp++;
            if (obs !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_hold cycle %0d: led/busy/done=%b required 000", cyc, obs);
            end
        end
        reset = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clock);
            obs = {bus.led, bus.busy, bus.done};
            n_cmp++;
            if (obs !== 3'b000) begin
                n_bad++;
                $display("FAIL idle cycle %0d: led/busy/done=%b required 000", cyc, obs);
            end
        end
    endtask

    task automatic test_single_blink();
        logic [2:0] obs, exp;
        bus.start = 1'b1;
        bus.count = 4'd1;
        push_seq(1);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clock);
            bus.start = 1'b0;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
            obs = {bus.led, bus.busy, bus.done};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL single_blink cycle %0d: led/busy/done=%b required %b", cyc, obs, exp);
            end
        end
    endtask

    task automatic test_ignored_start();
        logic [2:0] obs, exp;
        bus.start = 1'b1;
        bus.count = 4'd3;
        push_seq(3);
        for (int cyc = 1; cyc <= 19; cyc++) begin
            @(negedge clock);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
            obs = {bus.led, bus.busy, bus.done};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL three_blinks cycle %0d: led/busy/done=%b required %b", cyc, obs, exp);
            end
            // Requests mid-sequence and in the final OFF cycle must be dropped
            if (cyc == 3 || cyc == 15) begin
                bus.start = 1'b1;
                bus.count = 4'd5;
            end else begin
                bus.start = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] obs, exp;
        bus.start = 1'b1;
        bus.count = 4'd0;
        push_seq(0);
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clock);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
            obs = {bus.led, bus.busy, bus.done};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL back_to_back cycle %0d: led/busy/done=%b required %b", cyc, obs, exp);
            end
            // New request lands in the done cycle and must be accepted
            if (cyc == 1) begin
                bus.start = 1'b1;
                bus.count = 4'd2;
                push_seq(2);
            end else begin
                bus.start = 1'b0;
            end
        end
    endtask

    task automatic test_max_count();
        logic [2:0] obs, exp;
        logic       led_prev;
        int         rises, busy_cycles, dones;
        rises = 0;
        busy_cycles = 0;
        dones = 0;
        led_prev = 1'b0;
        bus.start = 1'b1;
        bus.count = 4'd15;
        push_seq(15);
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clock);
            bus.start = 1'b0;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
            obs = {bus.led, bus.busy, bus.done};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL max_count cycle %0d: led/busy/done=%b required %b", cyc, obs, exp);
            end
            if (bus.led === 1'b1 && led_prev === 1'b0) rises++;
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.done === 1'b1) dones++;
            led_prev = bus.led;
        end
        n_cmp++;
        if (rises !== 15) begin
            n_bad++;
            $display("FAIL max_count_led_rises: got %0d required 15", rises);
        end
        n_cmp++;
        if (busy_cycles !== 75) begin
            n_bad++;
            $display("FAIL max_count_busy_cycles: got %0d required 75", busy_cycles);
        end
        n_cmp++;
        if (dones !== 1) begin
            n_bad++;
            $display("FAIL max_count_done_pulses: got %0d required 1", dones);
        end
    endtask

    task automatic test_reset_mid_sequence();
        logic [2:0] obs, exp;
        bus.start = 1'b1;
        bus.count = 4'd4;
        push_seq(4);
        // Cycles 6..8 are the second ON period; abort inside cycle 7
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clock);
            bus.start = 1'b0;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
            obs = {bus.led, bus.busy, bus.done};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL pre_abort cycle %0d: led/busy/done=%b required %b", cyc, obs, exp);
            end
        end
        #2 reset = 1'b0;
        #1;
        exp_q.delete();
        obs = {bus.led, bus.busy, bus.done};
        n_cmp++;
        if (obs !== 3'b000) begin
            n_bad++;
            $display("FAIL async_abort: led/busy/done=%b required 000", obs);
        end
        @(negedge clock);
        obs = {bus.led, bus.busy, bus.done};
        n_cmp++;
        if (obs !== 3'b000) begin
            n_bad++;
            $display("FAIL abort_hold: led/busy/done=%b required 000", obs);
        end
        // Release and request in the same cycle: first edge with reset high takes it
        reset = 1'b1;
        bus.start = 1'b1;
        bus.count = 4'd1;
        push_seq(1);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clock);
            bus.start = 1'b0;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
            obs = {bus.led, bus.busy, bus.done};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL post_abort_blink cycle %0d: led/busy/done=%b required %b", cyc, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_blink();
        test_ignored_start();
        test_back_to_back();
        test_max_count();
        test_reset_mid_sequence();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
